// File: rtl/mips_mem_pkg.sv
// Shared MEM-stage types: store size encodings, bus widths and the packed write beat.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_mem_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } st_size_e;

  typedef struct packed {
    logic [DATA_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } wbeat_t;

endpackage

// File: rtl/store_fifo2.sv
// Two-entry valid/ready FIFO over a packed write beat; head is a register read.
// Latency: one cycle from push to out_vld; simultaneous push/pop keeps count.
// Backpressure: in_rdy depends only on the registered count, never on out_rdy.
module store_fifo2
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   in_vld,
  output logic   in_rdy,
  input  wbeat_t in_dat,
  output logic   out_vld,
  input  logic   out_rdy,
  output wbeat_t out_dat
);

  logic [1:0] count_q, count_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  wbeat_t     mem_q [2];
  wbeat_t     mem_d [2];
  logic       push, pop;

  assign in_rdy  = (count_q != 2'(DEPTH));
  assign out_vld = (count_q != 2'd0);
  assign out_dat = mem_q[rd_ptr_q];
  assign push    = in_vld && in_rdy;
  assign pop     = out_vld && out_rdy;

  // Next-state: write at wr_ptr, advance each pointer on its own handshake.
  always_comb begin
    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    if (push) mem_d[wr_ptr_q] = in_dat;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards every buffered entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
    end
  end

endmodule

// File: rtl/store_formatter.sv
// SB/SH/SW lane placement + strobes into a 2-entry buffer; misaligned/reserved rejected.
// Latency: beat on mem_wvalid one cycle after acceptance; st_err one cycle after.
// Backpressure: st_ready = buffer not full (registered); optional STORE_RANGE_CHECK_EN adds st_trunc.
module store_formatter
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [1:0]        st_size,
  input  logic [DATA_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              mem_wvalid,
  input  logic              mem_wready,
  output logic [DATA_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  output logic              st_err,
  output logic [DATA_W-1:0] st_err_addr
`ifdef STORE_RANGE_CHECK_EN
  ,
  output logic              st_trunc
`endif
);

  wbeat_t            beat;
  wbeat_t            head;
  logic              aligned;
  logic              accept, push;
  logic              err_q, err_d;
  logic [DATA_W-1:0] err_addr_q, err_addr_d;

  // Narrow the operand and place it on lanes; flag alignment legality.
  always_comb begin
    beat.waddr = {st_addr[31:2], 2'b00};
    beat.wdata = st_data;
    beat.wstrb = 4'b0000;
    aligned    = 1'b0;
    case (st_size)
      SZ_BYTE: begin
        beat.wdata = {4{st_data[7:0]}};
        beat.wstrb = 4'b0001 << st_addr[1:0];
        aligned    = 1'b1;
      end
      SZ_HALF: begin
        beat.wdata = {2{st_data[15:0]}};
        beat.wstrb = st_addr[1] ? 4'b1100 : 4'b0011;
        aligned    = !st_addr[0];
      end
      SZ_WORD: begin
        beat.wstrb = 4'b1111;
        aligned    = (st_addr[1:0] == 2'b00);
      end
      default: aligned = 1'b0;
    endcase
  end

  assign accept = st_valid && st_ready;
  assign push   = accept && aligned;

  store_fifo2 #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (push),
    .in_rdy  (st_ready),
    .in_dat  (beat),
    .out_vld (mem_wvalid),
    .out_rdy (mem_wready),
    .out_dat (head)
  );

  assign mem_waddr = head.waddr;
  assign mem_wdata = head.wdata;
  assign mem_wstrb = head.wstrb;

  // Rejected requests complete the handshake but only raise the error pulse.
  always_comb begin
    err_d      = accept && !aligned;
    err_addr_d = err_d ? st_addr : err_addr_q;
  end

  // Error pulse and sticky error address registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign st_err      = err_q;
  assign st_err_addr = err_addr_q;

`ifdef STORE_RANGE_CHECK_EN
  logic trunc_q, trunc_d;
  logic fits_byte, fits_half;

  // Operand fits when its upper bits are a pure sign extension of the stored width.
  always_comb begin
    fits_byte = (&st_data[31:7])  || !(|st_data[31:7]);
    fits_half = (&st_data[31:15]) || !(|st_data[31:15]);
    trunc_d   = push && (((st_size == SZ_BYTE) && !fits_byte) ||
                         ((st_size == SZ_HALF) && !fits_half));
  end

  // Truncation pulse register.
  always_ff @(posedge clk) begin
    if (rst) trunc_q <= 1'b0;
    else     trunc_q <= trunc_d;
  end

  assign st_trunc = trunc_q;
`endif

endmodule

// File: tb/tb_store_formatter.sv
// Directed + randomized bench for store_formatter with a queue-based reference model.
// Inputs change just after the falling edge; outputs are checked on the falling edge.
// Optional STORE_RANGE_CHECK_EN adds st_trunc checks.
module tb_store_formatter;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [1:0]  st_size;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        mem_wvalid;
  logic        mem_wready;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        st_err;
  logic [31:0] st_err_addr;
`ifdef STORE_RANGE_CHECK_EN
  logic        st_trunc;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  store_formatter #(.DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .st_size     (st_size),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .mem_wvalid  (mem_wvalid),
    .mem_wready  (mem_wready),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .st_err      (st_err),
    .st_err_addr (st_err_addr)
`ifdef STORE_RANGE_CHECK_EN
    ,
    .st_trunc    (st_trunc)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1;
    st_size  = sz;
    st_addr  = a;
    st_data  = d;
    @(negedge clk);
    st_valid = 1'b0;
  endtask

  // Reference: what a store of this size/address should write, from the lane rules.
  task automatic model_fmt(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                           output bit ok, output logic [67:0] b);
    int unsigned lane;
    logic [31:0] wd;
    logic [3:0]  ws;
    lane = a % 4;
    ok = 0;
    wd = 0;
    ws = 0;
    if (sz == 2'd0) begin
      ok = 1; wd = (d & 32'hFF) * 32'h0101_0101; ws = 4'(1 << lane);
    end else if (sz == 2'd1) begin
      ok = (a % 2 == 0); wd = (d & 32'hFFFF) * 32'h0001_0001; ws = 4'(3 << lane);
    end else if (sz == 2'd2) begin
      ok = (lane == 0); wd = d; ws = 4'hF;
    end
    b = {a - lane, wd, ws};
  endtask

  function automatic bit model_trunc(input logic [1:0] sz, input logic [31:0] d);
    int s;
    s = $signed(d);
    if (sz == 2'd0) return (s < -128 || s > 127);
    if (sz == 2'd1) return (s < -32768 || s > 32767);
    return 0;
  endfunction

  logic [67:0] q[$];
  logic [67:0] nb;
  bit          ok_m, acc_m, pop_m, exp_err, exp_trunc;
  logic [31:0] exp_err_addr;

  initial begin
    rst = 1'b1; st_valid = 1'b0; st_size = 2'd0; st_addr = '0; st_data = '0; mem_wready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_wvalid", mem_wvalid, 0);
    chk("rst_waddr", mem_waddr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_wstrb", mem_wstrb, 0);
    chk("rst_err", st_err, 0);
    chk("rst_err_addr", st_err_addr, 0);
    chk("rst_ready", st_ready, 1);
    rst = 1'b0;

    // Lane placement examples
    send(2'd0, 32'h1003, 32'hFFFF_FFA5);
    chk("sb_wvalid", mem_wvalid, 1);
    chk("sb_waddr", mem_waddr, 32'h1000);
    chk("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
    chk("sb_wstrb", mem_wstrb, 4'b1000);
    send(2'd1, 32'h2002, 32'h0000_1234);
    chk("sh_waddr", mem_waddr, 32'h2000);
    chk("sh_wdata", mem_wdata, 32'h1234_1234);
    chk("sh_wstrb", mem_wstrb, 4'b1100);
    send(2'd2, 32'h3000, 32'hDEAD_BEEF);
    chk("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("sw_wstrb", mem_wstrb, 4'b1111);
    @(negedge clk);
    chk("idle_wvalid", mem_wvalid, 0);

    // Rejections
    send(2'd2, 32'h3002, 32'h1);
    chk("rej_sw_wvalid", mem_wvalid, 0);
    chk("rej_sw_err", st_err, 1);
    chk("rej_sw_addr", st_err_addr, 32'h3002);
    @(negedge clk);
    chk("rej_pulse_end", st_err, 0);
    chk("rej_addr_hold", st_err_addr, 32'h3002);
    send(2'd1, 32'h2001, 32'h2);
    chk("rej_sh_err", st_err, 1);
    chk("rej_sh_addr", st_err_addr, 32'h2001);
    send(2'd3, 32'h0, 32'h3);
    chk("rej_rsv_wvalid", mem_wvalid, 0);
    chk("rej_rsv_err", st_err, 1);
    chk("rej_rsv_addr", st_err_addr, 32'h0);

    // Backpressure: fill, stall the third, then drain in order
    mem_wready = 1'b0;
    send(2'd2, 32'h4000, 32'h1111_1111);
    send(2'd2, 32'h4004, 32'h2222_2222);
    chk("bp_full_ready", st_ready, 0);
    chk("bp_head_addr", mem_waddr, 32'h4000);
    st_valid = 1'b1; st_size = 2'd2; st_addr = 32'h4008; st_data = 32'h3333_3333;
    @(negedge clk);
    chk("bp_stall_ready", st_ready, 0);
    chk("bp_stable_addr", mem_waddr, 32'h4000);
    chk("bp_stable_data", mem_wdata, 32'h1111_1111);
    mem_wready = 1'b1;
    @(negedge clk);
    chk("bp_drain1_addr", mem_waddr, 32'h4004);
    chk("bp_drain1_ready", st_ready, 1);
    @(negedge clk);
    st_valid = 1'b0;
    chk("bp_drain2_addr", mem_waddr, 32'h4008);
    chk("bp_drain2_data", mem_wdata, 32'h3333_3333);
    @(negedge clk);
    chk("bp_empty", mem_wvalid, 0);

    // Streaming at one beat per cycle
    for (int i = 0; i < 6; i++) begin
      st_valid = 1'b1; st_size = 2'd2; st_addr = 32'h5000 + 32'(4 * i); st_data = 32'(i);
      @(negedge clk);
      chk("stream_wvalid", mem_wvalid, 1);
      chk("stream_waddr", mem_waddr, 32'h5000 + 32'(4 * i));
    end
    st_valid = 1'b0;
    @(negedge clk);
    chk("stream_end", mem_wvalid, 0);

    // Reset with two entries buffered
    mem_wready = 1'b0;
    send(2'd2, 32'h6000, 32'hA);
    send(2'd2, 32'h6004, 32'hB);
    chk("mid_rst_pre", mem_wvalid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_wvalid", mem_wvalid, 0);
    chk("mid_rst_ready", st_ready, 1);
    mem_wready = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_nothing", mem_wvalid, 0);
    chk("mid_rst_noerr", st_err, 0);

`ifdef STORE_RANGE_CHECK_EN
    send(2'd0, 32'h0, 32'h0000_0180);
    chk("trunc_pulse", st_trunc, 1);
    chk("trunc_writes", mem_wvalid, 1);
    @(negedge clk);
    chk("trunc_end", st_trunc, 0);
    send(2'd0, 32'h0, 32'hFFFF_FF80);
    chk("trunc_none", st_trunc, 0);
`endif

    // Randomized traffic against the queue model
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    exp_err = 0; exp_err_addr = 0; exp_trunc = 0;
    for (int c = 0; c < 400; c++) begin
      chk("rnd_ready", st_ready, (q.size() != 2));
      chk("rnd_wvalid", mem_wvalid, (q.size() != 0));
      if (q.size() != 0) begin
        chk("rnd_waddr", mem_waddr, q[0][67:36]);
        chk("rnd_wdata", mem_wdata, q[0][35:4]);
        chk("rnd_wstrb", mem_wstrb, 32'(q[0][3:0]));
      end
      chk("rnd_err", st_err, exp_err);
      chk("rnd_err_addr", st_err_addr, exp_err_addr);
`ifdef STORE_RANGE_CHECK_EN
      chk("rnd_trunc", st_trunc, exp_trunc);
`endif
      st_valid   = ($urandom_range(0, 3) != 0);
      st_size    = 2'($urandom_range(0, 3));
      st_addr    = $urandom;
      st_data    = ($urandom_range(0, 1) != 0) ? $urandom : 32'($signed(16'($urandom)));
      mem_wready = ($urandom_range(0, 2) != 0);
      model_fmt(st_size, st_addr, st_data, ok_m, nb);
      acc_m     = st_valid && (q.size() != 2);
      pop_m     = (q.size() != 0) && mem_wready;
      exp_err   = acc_m && !ok_m;
      if (exp_err) exp_err_addr = st_addr;
      exp_trunc = acc_m && ok_m && model_trunc(st_size, st_data);
      if (pop_m) void'(q.pop_front());
      if (acc_m && ok_m) q.push_back(nb);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_formatter.md
# store_formatter

Store-path formatter for the MIPS MEM stage: accepts SW/SH/SB requests from the pipeline, narrows the 32-bit register operand to the requested width, and places it on the correct byte lanes with byte strobes toward data memory. It is the write-direction counterpart of the load path's 16→32 and 8→32 sign extension. A two-entry buffer decouples pipeline issue from memory acceptance. Misaligned or reserved-size stores are rejected with an error pulse rather than written.

## Interface
- `DEPTH`, 2, buffer entries; only 2 is supported.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `st_valid`  in  1  store request valid.
- `st_ready`  out  1  formatter can accept a request this cycle.
- `st_size`  in  2  00 byte, 01 half, 10 word, 11 reserved.
- `st_addr`  in  32  byte address.
- `st_data`  in  32  register operand; the low bits carry the store value.
- `mem_wvalid`  out  1  write beat valid.
- `mem_wready`  in  1  memory accepts the beat.
- `mem_waddr`  out  32  word address, `{st_addr[31:2],2'b00}`.
- `mem_wdata`  out  32  lane-placed data.
- `mem_wstrb`  out  4  byte enables; bit i enables `mem_wdata[8i+7:8i]`.
- `st_err`  out  1  one-cycle pulse: the request was rejected.
- `st_err_addr`  out  32  address of the rejected request; holds until the next error.

## Operation
- A request is accepted when `st_valid && st_ready`; `st_ready = (count != 2)`.
- Little-endian lane mapping. `a = st_addr[1:0]`.
- **Byte** (any `a`):
  - `wdata = {4{st_data[7:0]}}`.
  - `wstrb = 4'b0001 << a`.
- **Half:**
  - `a[0]` must be 0.
  - `wdata = {2{st_data[15:0]}}`.
  - `wstrb = a[1] ? 4'b1100 : 4'b0011`.
- **Word:**
  - `a` must be 00.
  - `wdata = st_data`.
  - `wstrb = 4'b1111`.
- **Reject:** a misaligned half or word, or size 11.
  - The request is accepted (handshake completes) but is not enqueued.
  - Next cycle: `st_err = 1` and `st_err_addr = st_addr`.
- **Buffer:**
  - FIFO of `{waddr, wdata, wstrb}` with a `count` of 0..2 and 1-bit read/write pointers that wrap.
  - Head drives the `mem_*` outputs. `mem_wvalid = (count != 0)`.
  - Pop on `mem_wvalid && mem_wready`.
- **Simultaneous push and pop:**
  - `count` is unchanged.
  - Both pointers advance.
  - With `count = 1`, the new entry becomes head in the following cycle.
- Outputs are stable while `mem_wvalid && !mem_wready`; no entry is dropped or reordered.
- A rejected request in the same cycle as a pop: the pop proceeds and `count` decrements.

## Timing
- Latency: an accepted valid store appears on `mem_wvalid` the next cycle at the earliest; the path is registered, with no combinational path from `st_*` to `mem_*`.
- `st_ready` depends only on registered `count`, not on `mem_wready`, so a full buffer stalls for one cycle after a pop.
- Throughput: one store per cycle sustained while `mem_wready = 1`.
- Reset values:
  - `count = 0`, pointers = 0.
  - `mem_wvalid = 0`, `mem_waddr = 0`, `mem_wdata = 0`, `mem_wstrb = 0`.
  - `st_err = 0`, `st_err_addr = 0`.
  - `st_ready = 1` from the first cycle after reset.
- Reset mid-operation: buffered entries are discarded; nothing is written afterwards and no error is reported for them.

## Configuration
- `STORE_RANGE_CHECK_EN`:
  - **Defined:** a byte or half store whose `st_data` is not the sign extension of its low 8 or 16 bits (that is, `st_data[31:7]` or `st_data[31:15]` is not all-equal) still writes normally.
  - It also pulses `st_trunc` (an extra 1-bit output) one cycle after acceptance.
  - **Undefined:** no `st_trunc` port exists and the check logic is absent.

## Structure
- Shared package `mips_mem_pkg`:
  - Size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`.
  - Width constants: data 32, strobe 4.
  - The packed write-beat struct `{waddr, wdata, wstrb}`.
- Sub-module `store_fifo2`:
  - Generic two-entry valid/ready FIFO over the packed beat.
  - The top level holds the formatting logic and the error and range-check registers.

## Test plan
- SB: addr 0x1003, data 0xFFFF_FFA5 → `waddr` 0x1000, `wdata` 0xA5A5_A5A5, `wstrb` 1000 one cycle later.
- SH: addr 0x2002, data 0x0000_1234 → `wdata` 0x1234_1234, `wstrb` 1100. SW: addr 0x3000, data 0xDEAD_BEEF → `wstrb` 1111.
- SW to 0x3002, SH to 0x2001, and size 11 to 0x0 → no `mem_wvalid`, `st_err` pulse, `st_err_addr` 0x3002, 0x2001, 0x0 respectively.
- Hold `mem_wready = 0` and issue 3 stores:
  - Expect `st_ready` low after 2.
  - Outputs stable on the head.
  - Release: the beats drain in order and the third is accepted.
- Continuous stores with `mem_wready = 1` → one beat per cycle. Assert `rst` with 2 entries buffered → `mem_wvalid = 0` the next cycle and `count = 0`.
- With `STORE_RANGE_CHECK_EN`: SB with data 0x0000_0180 → `st_trunc` pulse. SB with data 0xFFFF_FF80 → no pulse.
